// File: rtl/alu_simd_pkg.sv
// alu_simd_pkg: shared SIMD mode encodings, lane limit and lane-count helper
package alu_simd_pkg;

    localparam int LANES_MAX = 4;

    typedef enum logic [1:0] {
        MODE_1L = 2'b00,
        MODE_2L = 2'b01,
        MODE_4L = 2'b10
    } simd_mode_t;

    function automatic int lanes_of(logic [1:0] mode);
        return (mode == MODE_2L) ? 2 : (mode == MODE_4L) ? 4 : 1;
    endfunction

endpackage

// File: rtl/alu_simd_pipe_if.sv
// alu_simd_pipe_if: operand/result bundle between the MAC datapath and the SIMD ALU
interface alu_simd_pipe_if #(
    parameter int WIDTH     = 48,
    parameter int LANES_MAX = 4
);
    logic                   ce;
    logic                   in_valid;
    logic [1:0]             simd_mode;
    logic                   acc;
    logic [WIDTH-1:0]       w;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
    logic [LANES_MAX-1:0]   cin;
    logic [WIDTH-1:0]       s;
    logic [2*LANES_MAX-1:0] cout;
    logic                   out_valid;

    modport master (output ce, in_valid, simd_mode, acc, w, x, y, cin, input s, cout, out_valid);
    modport slave  (input ce, in_valid, simd_mode, acc, w, x, y, cin, output s, cout, out_valid);
endinterface

// File: rtl/alu_simd_adder.sv
// alu_simd_adder: combinational three-input lane-split adder; ALU_SIMD_SAT_EN enables per-lane saturation
module alu_simd_adder
    import alu_simd_pkg::*;
#(
    parameter int WIDTH = 48
) (
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       w,
    input  logic [WIDTH-1:0]       x,
    input  logic [WIDTH-1:0]       y,
    input  logic [LANES_MAX-1:0]   cin,
    output logic [WIDTH-1:0]       s,
    output logic [2*LANES_MAX-1:0] cout
);
    logic [2:0][WIDTH-1:0]       s_c;
    logic [2:0][2*LANES_MAX-1:0] c_c;

    // One adder set per lane configuration; carries never leave their lane
    for (genvar m = 0; m < 3; m++) begin : g_mode
        localparam int N  = 1 << m;
        localparam int LW = WIDTH / N;
        for (genvar g = 0; g < LANES_MAX; g++) begin : g_lane
            if (g < N) begin : g_on
                logic [LW+1:0] sum;
                assign sum = {2'b00, w[g*LW +: LW]} + {2'b00, x[g*LW +: LW]}
                           + {2'b00, y[g*LW +: LW]} + {{(LW+1){1'b0}}, cin[g]};
`ifdef ALU_SIMD_SAT_EN
                assign s_c[m][g*LW +: LW] = (sum[LW+1:LW] != 2'b00) ? '1 : sum[LW-1:0];
`else
                assign s_c[m][g*LW +: LW] = sum[LW-1:0];
`endif
                assign c_c[m][2*g +: 2] = sum[LW+1:LW];
            end else begin : g_off
                assign c_c[m][2*g +: 2] = 2'b00;
            end
        end
    end

    // Pick the configuration requested at runtime; mode 11 falls back to one lane
    always_comb begin
        s    = (lanes_of(mode) == 4) ? s_c[2] : (lanes_of(mode) == 2) ? s_c[1] : s_c[0];
        cout = (lanes_of(mode) == 4) ? c_c[2] : (lanes_of(mode) == 2) ? c_c[1] : c_c[0];
    end
endmodule

// File: rtl/alu_simd_pipe.sv
// alu_simd_pipe: two-stage SIMD three-input adder with accumulate feedback; ALU_SIMD_SAT_EN enables saturation
module alu_simd_pipe #(
    parameter int WIDTH     = 48,
    parameter int LANES_MAX = alu_simd_pkg::LANES_MAX
) (
    input logic            clk,
    input logic            reset,
    alu_simd_pipe_if.slave bus
);
    logic [WIDTH-1:0]       r_w;
    logic [WIDTH-1:0]       r_x;
    logic [WIDTH-1:0]       r_y;
    logic [LANES_MAX-1:0]   r_cin;
    logic [1:0]             r_mode;
    logic                   r_acc;
    logic                   r_valid;
    logic [WIDTH-1:0]       w_op;
    logic [WIDTH-1:0]       sum_s;
    logic [2*LANES_MAX-1:0] sum_c;

    assign w_op = r_acc ? bus.s : r_w;

    alu_simd_adder #(.WIDTH(WIDTH)) u_add (
        .mode (r_mode),
        .w    (w_op),
        .x    (r_x),
        .y    (r_y),
        .cin  (r_cin),
        .s    (sum_s),
        .cout (sum_c)
    );

    // Stage 1: capture operands and controls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_cin   <= '0;
            r_mode  <= '0;
            r_acc   <= 1'b0;
            r_valid <= 1'b0;
        end else if (bus.ce) begin
            r_w     <= bus.w;
            r_x     <= bus.x;
            r_y     <= bus.y;
            r_cin   <= bus.cin;
            r_mode  <= bus.simd_mode;
            r_acc   <= bus.acc;
            r_valid <= bus.in_valid;
        end
    end

    // Stage 2: register the sum; invalid beats still update S so accumulation stays in step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.s         <= '0;
            bus.cout      <= '0;
            bus.out_valid <= 1'b0;
        end else if (bus.ce) begin
            bus.s         <= sum_s;
            bus.cout      <= sum_c;
            bus.out_valid <= r_valid;
        end
    end
endmodule
